// File: rtl/ram_rd_pkg.sv
// ---------------------------------------------------------------------------
// ram_rd_pkg
// Shared definitions for the RAM burst reader: default widths and the
// controller state encoding.
// ---------------------------------------------------------------------------
package ram_rd_pkg;

    localparam int ADDR_W_DEF     = 12;  // 4096-word RAM
    localparam int DATA_W_DEF     = 64;  // RAM word / stream beat width
    localparam int LEN_W_DEF      = 13;  // burst length 1..4096 beats
    localparam int FIFO_DEPTH_DEF = 4;   // output buffer entries

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a request
        ISSUE = 2'd1,   // issuing RAM reads
        DRAIN = 2'd2    // all reads issued, waiting for the last beat to leave
    } state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// ---------------------------------------------------------------------------
// ram_rd_fifo
// Synchronous first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on head_data_o whenever empty_o is low.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (clears pointers and count)
//   push_i       write push_data_i this cycle
//   push_data_i  entry to store
//   pop_i        consumer takes the head entry this cycle (ignored when empty)
//   head_data_o  current head entry
//   empty_o      no entries stored
//   count_o      number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module ram_rd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o     = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;  // idle, or push and pop together
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // The upstream credit scheme must never offer a word with no room for it.
    overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/ram_burst_reader.sv
// ---------------------------------------------------------------------------
// ram_burst_reader
// Accepts a burst request (start address, beat count), reads that many
// consecutive words from a synchronous RAM (1-cycle read latency, address
// wraps at 2^ADDR_W) and streams them out through a small FWFT buffer,
// marking the final beat with m_last.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side may only be accepted in IDLE; the output
// side holds m_data/m_last stable while m_valid is high and m_ready is low.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  request handshake; req_addr/req_len are the burst
//   rd, rd_add           RAM read enable / address (rd_add is 0 when rd is 0)
//   rd_data              RAM read data, valid the cycle after rd
//   m_valid/m_ready      output beat handshake; m_data/m_last are the beat
//   busy                 controller is not IDLE
//   dbg_state            current controller state
// ---------------------------------------------------------------------------
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rd,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output state_e            dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;       // a read was issued last cycle
    logic              inflight_last_q;  // ... and it was the burst's final read

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              issue;
    logic              last_read;
    logic              accept;
    logic              pop;

    // Buffer slots already spoken for: stored words plus the word whose
    // RAM read is still in flight. A new read only goes out if a slot is
    // guaranteed, so the buffer can never overflow even with m_ready low.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

    assign issue     = (state_q == ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign last_read = issue && (remaining_q == LEN_W'(1));

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign rd        = issue;
    assign rd_add    = issue ? addr_q : '0;

    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[DATA_W-1:0];
    assign m_last    = m_valid && fifo_head[DATA_W];
    assign pop       = m_valid && m_ready;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_read;
            case (state_q)
                IDLE: begin
                    // A zero-length request is accepted and simply discarded.
                    if (accept && (req_len != '0)) begin
                        addr_q      <= req_addr;
                        remaining_q <= req_len;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q      <= addr_q + ADDR_W'(1);  // wraps naturally
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (last_read) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Returning RAM data is tagged with the last flag of the read it answers.
    // Reset clears inflight_q, so data for a read issued before reset is dropped.
    ram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rd_data}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_reader
// Directed bench for ram_burst_reader with a RAM model and a burst-level
// reference: each accepted request expands into the list of addresses that
// must be read and the list of beats (data, last) that must come out.
// ---------------------------------------------------------------------------
module tb_ram_burst_reader;
    import ram_rd_pkg::*;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 13;
    localparam int FIFO_DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              rd;
    logic [ADDR_W-1:0] rd_add;
    logic [DATA_W-1:0] rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    state_e            dbg_state;

    always #5 clk = ~clk;

    ram_burst_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd        (rd),
        .rd_add    (rd_add),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- RAM model ----------------
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return {20'hC0DE0, a, ~{20'h0, a}};
    endfunction

    // Garbage when not read, so a spurious push is visible.
    always @(posedge clk) begin
        rd_data <= rd ? ram_word(rd_add) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W:0]   exp_q[$];      // {last, data} per expected beat
    logic [ADDR_W-1:0] exp_rd_q[$];   // expected read addresses
    logic [ADDR_W-1:0] rd_log[$];     // observed read addresses (per test)
    int rd_cnt   = 0;
    int beat_cnt = 0;
    int last_cnt = 0;
    int issued   = 0;
    int taken    = 0;
    int ready_mode = 0;               // 0: ready=1, 1: ready=0, 2: random
    logic            hold_valid = 1'b0;
    logic [DATA_W:0] hold_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- output consumer ----------------
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (!rd) begin
                check("rd_add_idle", 64'(rd_add), 64'h0);
            end else begin
                rd_log.push_back(rd_add);
                rd_cnt++;
                issued++;
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 64'(rd_add), 64'hFFFF_FFFF);
                end else begin
                    check("rd_add", 64'(rd_add), 64'(exp_rd_q.pop_front()));
                end
                check("no_overflow", 64'(issued - taken <= FIFO_DEPTH), 64'h1);
            end
            if (m_valid) begin
                if (hold_valid) begin
                    check("hold_stable", {m_last, m_data}, hold_beat);
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", m_data, 64'h0);
                    end else begin
                        check("beat", {m_last, m_data}, exp_q.pop_front());
                    end
                    taken++;
                    beat_cnt++;
                    if (m_last) last_cnt++;
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    hold_beat  = {m_last, m_data};
                end
            end else begin
                hold_valid = 1'b0;
                check("m_last_without_valid", 64'(m_last), 64'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = len;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", 64'(n < 50), 64'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            logic [ADDR_W-1:0] wa;
            wa = a + ADDR_W'(i);
            exp_rd_q.push_back(wa);
            exp_q.push_back({(i == int'(len) - 1), ram_word(wa)});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: idle timeout after %0d cycles, %0d beats outstanding",
                     name, n, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_test_counters();
        rd_log.delete();
        rd_cnt   = 0;
        beat_cnt = 0;
        last_cnt = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd", 64'(rd), 64'h0);
        check("rst_rd_add", 64'(rd_add), 64'h0);
        check("rst_m_valid", 64'(m_valid), 64'h0);
        check("rst_m_last", 64'(m_last), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'h1);
        check("post_rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1;

        // Basic burst: addr 0x010, len 4, latency and literal data
        ready_mode = 0;
        clear_test_counters();
        send_req(12'h010, 13'd4);
        check("t1_busy_after_accept", 64'(busy), 64'h1);
        @(negedge clk);
        check("t1_lat1_m_valid", 64'(m_valid), 64'h0);
        @(negedge clk);
        check("t1_lat2_m_valid", 64'(m_valid), 64'h0);
        @(negedge clk);
        check("t1_first_m_valid", 64'(m_valid), 64'h1);
        check("t1_first_data", m_data, 64'hC0DE0010_FFFFFFEF);
        wait_idle("t1", 100);
        check("t1_busy_low", 64'(busy), 64'h0);
        check("t1_beats", 64'(beat_cnt), 64'd4);
        check("t1_lasts", 64'(last_cnt), 64'd1);
        check("t1_rd_count", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            check("t1_rd0", 64'(rd_log[0]), 64'h010);
            check("t1_rd3", 64'(rd_log[3]), 64'h013);
        end

        // Address wrap: 0xFFE, len 4
        clear_test_counters();
        send_req(12'hFFE, 13'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t2_first_data", m_data, 64'hC0DE0FFE_FFFFF001);
        wait_idle("t2", 100);
        check("t2_rd_count", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            check("t2_rd0", 64'(rd_log[0]), 64'hFFE);
            check("t2_rd1", 64'(rd_log[1]), 64'hFFF);
            check("t2_rd2", 64'(rd_log[2]), 64'h000);
            check("t2_rd3", 64'(rd_log[3]), 64'h001);
        end

        // Back-pressure: len 8, consumer stalled for 20 cycles
        ready_mode = 1;
        @(posedge clk);
        #1;
        clear_test_counters();
        send_req(12'h200, 13'd8);
        repeat (20) @(negedge clk);
        check("t3_reads_while_stalled", 64'(rd_cnt), 64'd4);
        check("t3_stalled_valid", 64'(m_valid), 64'h1);
        check("t3_stalled_data", m_data, 64'hC0DE0200_FFFFFDFF);
        check("t3_stalled_busy", 64'(busy), 64'h1);
        ready_mode = 0;
        @(posedge clk);
        #1;
        wait_idle("t3", 200);
        check("t3_beats", 64'(beat_cnt), 64'd8);
        check("t3_reads", 64'(rd_cnt), 64'd8);

        // Zero-length request
        clear_test_counters();
        send_req(12'h050, 13'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_req_ready", 64'(req_ready), 64'h1);
            check("t4_m_valid", 64'(m_valid), 64'h0);
            check("t4_busy", 64'(busy), 64'h0);
        end
        check("t4_no_reads", 64'(rd_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Reset on the 3rd beat of a len-16 burst
        clear_test_counters();
        send_req(12'h300, 13'd16);
        n = 0;
        while (beat_cnt < 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t5_reach_beat3", 64'(n < 100), 64'h1);
        check("t5_beat3_valid", 64'(m_valid), 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_rst_rd", 64'(rd), 64'h0);
        check("t5_rst_rd_add", 64'(rd_add), 64'h0);
        check("t5_rst_m_valid", 64'(m_valid), 64'h0);
        check("t5_rst_m_last", 64'(m_last), 64'h0);
        check("t5_rst_busy", 64'(busy), 64'h0);
        check("t5_rst_req_ready", 64'(req_ready), 64'h0);
        exp_q.delete();
        exp_rd_q.delete();
        issued = 0;
        taken  = 0;
        clear_test_counters();
        rst = 1'b0;
        @(negedge clk);
        check("t5_dropped_inflight", 64'(m_valid), 64'h0);
        check("t5_req_ready_back", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        send_req(12'h400, 13'd2);
        wait_idle("t5_new", 100);
        check("t5_new_beats", 64'(beat_cnt), 64'd2);
        check("t5_new_lasts", 64'(last_cnt), 64'd1);

        // Full-RAM burst with random back-pressure
        ready_mode = 2;
        clear_test_counters();
        send_req(12'h123, 13'd4096);
        wait_idle("t6", 40000);
        check("t6_beats", 64'(beat_cnt), 64'd4096);
        check("t6_reads", 64'(rd_cnt), 64'd4096);
        check("t6_lasts", 64'(last_cnt), 64'd1);
        check("t6_state", 64'(dbg_state), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
